ahb_slave_if: RTL and testbench

AHB_SLAVE_IF -- requirements
Module: ahb_slave_if

---
 rtl/ahb_pkg.sv | 46 ++++
 rtl/ahb_slave_if.sv | 127 ++++++++++++
 tb/tb_ahb_slave_if.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB encodings (HTRANS/HBURST/HSIZE) and the slave FSM state indices,
// common to the AHB slave and master interface blocks.
package ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4WORD = 3'd4,
        HSIZE_8WORD = 3'd5,
        HSIZE_16W   = 3'd6,
        HSIZE_32W   = 3'd7
    } hsize_t;

    localparam int ST_IDX_IDLE   = 0;
    localparam int ST_IDX_ACCESS = 1;
    localparam int ST_IDX_ERR1   = 2;
    localparam int ST_IDX_ERR2   = 3;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'(1 << ST_IDX_IDLE),
        ST_ACCESS = 4'(1 << ST_IDX_ACCESS),
        ST_ERR1   = 4'(1 << ST_IDX_ERR1),
        ST_ERR2   = 4'(1 << ST_IDX_ERR2)
    } slave_state_t;

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite slave front end: turns each accepted beat into a single backend
// request, stretches the data phase on backend wait, and answers ERROR on
// illegal transfers, backend errors or backend timeout.
module ahb_slave_if
    import ahb_pkg::*;
#(
    parameter int AHB_ADDR_WIDTH   = 32,
    parameter int AHB_DATA_WIDTH   = 32,
    parameter int AHB_WAIT_TIMEOUT = 6
) (
    input  logic                      ahb_clk_in,
    input  logic                      ahb_rstn_in,
    input  logic                      ahb_sel_in,
    input  logic [AHB_ADDR_WIDTH-1:0] ahb_addr_in,
    input  logic [1:0]                ahb_trans_in,
    input  logic [2:0]                ahb_burst_in,
    input  logic [2:0]                ahb_size_in,
    input  logic                      ahb_write_in,
    input  logic                      ahb_ready_in,
    input  logic [AHB_DATA_WIDTH-1:0] ahb_wdata_in,
    output logic [AHB_DATA_WIDTH-1:0] ahb_rdata_out,
    output logic                      ahb_readyout_out,
    output logic                      ahb_resp_out,
    output logic                      other_valid_out,
    output logic [AHB_ADDR_WIDTH-1:0] other_addr_out,
    output logic                      other_write_out,
    output logic [2:0]                other_size_out,
    output logic [AHB_DATA_WIDTH-1:0] other_wdata_out,
    input  logic                      other_ready_in,
    input  logic                      other_error_in,
    input  logic [AHB_DATA_WIDTH-1:0] other_rdata_in
);

    localparam int CNT_W = $clog2(AHB_WAIT_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AHB_WAIT_TIMEOUT - 1);

    slave_state_t              state_reg;
    logic [CNT_W-1:0]          wait_cnt_reg;
    logic [AHB_ADDR_WIDTH-1:0] addr_reg;
    logic                      write_reg;
    logic [2:0]                size_reg;

    logic                      accept;
    logic                      oversize;
    logic                      misaligned;
    logic                      invalid;
    logic                      access_ok;
    logic                      take_new;
    logic [AHB_ADDR_WIDTH-1:0] align_mask;
    logic                      burst_unused;

    // Burst type carries no meaning here: every beat is a standalone request.
    assign burst_unused = ^ahb_burst_in;

    assign accept = ahb_sel_in && ahb_ready_in &&
                    ((ahb_trans_in == HTRANS_NONSEQ) || (ahb_trans_in == HTRANS_SEQ));

    assign align_mask = (AHB_ADDR_WIDTH'(1) << ahb_size_in) - AHB_ADDR_WIDTH'(1);
    assign misaligned = |(ahb_addr_in & align_mask);
    assign oversize   = (32'd8 << ahb_size_in) > 32'(AHB_DATA_WIDTH);
    assign invalid    = oversize || misaligned;

    assign access_ok = (state_reg == ST_ACCESS) && other_ready_in && !other_error_in;

    // A new address phase can only land where the data phase is finishing with HREADY high.
    assign take_new = accept &&
                      ((state_reg == ST_IDLE) || (state_reg == ST_ERR2) || access_ok);

    always_ff @(posedge ahb_clk_in or negedge ahb_rstn_in) begin
        if (!ahb_rstn_in) begin
            state_reg    <= ST_IDLE;
            wait_cnt_reg <= '0;
            addr_reg     <= '0;
            write_reg    <= 1'b0;
            size_reg     <= '0;
        end else if (take_new) begin
            addr_reg     <= ahb_addr_in;
            write_reg    <= ahb_write_in;
            size_reg     <= ahb_size_in;
            wait_cnt_reg <= '0;
            state_reg    <= invalid ? ST_ERR1 : ST_ACCESS;
        end else begin
            unique case (state_reg)
                ST_IDLE: state_reg <= ST_IDLE;
                ST_ACCESS: begin
                    if (other_ready_in) begin
                        state_reg <= other_error_in ? ST_ERR1 : ST_IDLE;
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        state_reg <= ST_ERR1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
                end
                ST_ERR1: state_reg <= ST_ERR2;
                ST_ERR2: state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign other_addr_out  = addr_reg;
    assign other_write_out = write_reg;
    assign other_size_out  = size_reg;

    always_comb begin
        ahb_readyout_out = 1'b1;
        ahb_resp_out     = 1'b0;
        ahb_rdata_out    = '0;
        other_valid_out  = 1'b0;
        other_wdata_out  = '0;
        unique case (state_reg)
            ST_ACCESS: begin
                other_valid_out  = 1'b1;
                other_wdata_out  = ahb_wdata_in;
                ahb_readyout_out = other_ready_in && !other_error_in;
                ahb_rdata_out    = write_reg ? '0 : other_rdata_in;
            end
            ST_ERR1: begin
                ahb_readyout_out = 1'b0;
                ahb_resp_out     = 1'b1;
            end
            ST_ERR2: ahb_resp_out = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ahb_slave_if.sv
// Directed bench for ahb_slave_if: backend requests are scoreboarded, bus
// responses are checked per cycle against fixed expectations.
module tb_ahb_slave_if;
    import ahb_pkg::*;

    logic        clk;
    logic        rstn;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic [2:0]  burst;
    logic [2:0]  size;
    logic        write;
    logic        hready;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        readyout;
    logic        resp;
    logic        o_valid;
    logic [31:0] o_addr;
    logic        o_write;
    logic [2:0]  o_size;
    logic [31:0] o_wdata;
    logic        o_ready;
    logic        o_error;
    logic [31:0] o_rdata;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    req_t sb[$];
    int   total = 0;
    int   bad   = 0;
    logic prev_valid = 1'b0;
    logic prev_ready = 1'b0;

    // Single-slave bus: HREADY is this slave's own HREADYOUT.
    assign hready = readyout;

    ahb_slave_if dut (
        .ahb_clk_in       (clk),
        .ahb_rstn_in      (rstn),
        .ahb_sel_in       (sel),
        .ahb_addr_in      (addr),
        .ahb_trans_in     (trans),
        .ahb_burst_in     (burst),
        .ahb_size_in      (size),
        .ahb_write_in     (write),
        .ahb_ready_in     (hready),
        .ahb_wdata_in     (wdata),
        .ahb_rdata_out    (rdata),
        .ahb_readyout_out (readyout),
        .ahb_resp_out     (resp),
        .other_valid_out  (o_valid),
        .other_addr_out   (o_addr),
        .other_write_out  (o_write),
        .other_size_out   (o_size),
        .other_wdata_out  (o_wdata),
        .other_ready_in   (o_ready),
        .other_error_in   (o_error),
        .other_rdata_in   (o_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                              input logic [1:0] tr, input logic [2:0] bu);
        sel   = 1'b1;
        addr  = a;
        size  = sz;
        write = wr;
        trans = tr;
        burst = bu;
    endtask

    task automatic bus_idle();
        sel   = 1'b0;
        addr  = '0;
        trans = HTRANS_IDLE;
        burst = HBURST_SINGLE;
        write = 1'b0;
        size  = HSIZE_WORD;
    endtask

    task automatic push(input logic [31:0] a, input logic [2:0] sz, input logic wr,
                        input logic [31:0] wd);
        req_t r;
        r.addr  = a;
        r.size  = sz;
        r.write = wr;
        r.wdata = wd;
        sb.push_back(r);
    endtask

    task automatic check_req();
        req_t r;
        chk("req_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            r = sb.pop_front();
            chk("req_addr", 64'(o_addr), 64'(r.addr));
            chk("req_write", 64'(o_write), 64'(r.write));
            chk("req_size", 64'(o_size), 64'(r.size));
            chk("req_wdata", 64'(o_wdata), 64'(r.wdata));
            $display("req addr=%h write=%0d size=%0d wdata=%h", o_addr, o_write, o_size, o_wdata);
        end
    endtask

    // Backend monitor: a request starts when valid rises or follows a finished one.
    always @(negedge clk) begin
        if (o_valid && (!prev_valid || prev_ready)) check_req();
        prev_valid <= o_valid;
        prev_ready <= o_ready;
    end

    task automatic expect_error(input string tag, input logic [31:0] a, input logic [2:0] sz);
        tick();
        addr_phase(a, sz, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
        @(negedge clk);
        tick();
        bus_idle();
        @(negedge clk);
        chk({tag, "_err1_ready"}, 64'(readyout), 64'd0);
        chk({tag, "_err1_resp"}, 64'(resp), 64'd1);
        chk({tag, "_err1_valid"}, 64'(o_valid), 64'd0);
        tick();
        @(negedge clk);
        chk({tag, "_err2_ready"}, 64'(readyout), 64'd1);
        chk({tag, "_err2_resp"}, 64'(resp), 64'd1);
        tick();
        @(negedge clk);
        chk({tag, "_idle_resp"}, 64'(resp), 64'd0);
        $display("error transfer %s addr=%h size=%0d", tag, a, sz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int vcnt;
        rstn    = 1'b0;
        wdata   = '0;
        o_ready = 1'b0;
        o_error = 1'b0;
        o_rdata = '0;
        bus_idle();

        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(readyout), 64'd1);
        chk("rst_resp", 64'(resp), 64'd0);
        chk("rst_rdata", 64'(rdata), 64'd0);
        chk("rst_valid", 64'(o_valid), 64'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(readyout), 64'd1);

        // Single zero-wait read
        tick();
        addr_phase(32'h100, HSIZE_WORD, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
        push(32'h100, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        bus_idle();
        o_ready = 1'b1;
        o_rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("rd_ready", 64'(readyout), 64'd1);
        chk("rd_resp", 64'(resp), 64'd0);
        chk("rd_rdata", 64'(rdata), 64'hDEADBEEF);
        chk("rd_valid", 64'(o_valid), 64'd1);
        $display("read 0x100 rdata=%h", rdata);
        tick();
        o_ready = 1'b0;
        @(negedge clk);
        chk("rd_idle_valid", 64'(o_valid), 64'd0);
        chk("rd_idle_rdata", 64'(rdata), 64'd0);

        // Write with three backend wait cycles
        tick();
        addr_phase(32'h204, HSIZE_WORD, 1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
        push(32'h204, HSIZE_WORD, 1'b1, 32'h55AA);
        @(negedge clk);
        tick();
        bus_idle();
        wdata = 32'h55AA;
        low = 0;
        repeat (3) begin
            @(negedge clk);
            if (!readyout) low++;
            tick();
        end
        o_ready = 1'b1;
        @(negedge clk);
        chk("wr_wait_cycles", 64'(low), 64'd3);
        chk("wr_done_ready", 64'(readyout), 64'd1);
        chk("wr_done_resp", 64'(resp), 64'd0);
        chk("wr_done_wdata", 64'(o_wdata), 64'h55AA);
        chk("wr_done_rdata", 64'(rdata), 64'd0);
        $display("write 0x204 wait=%0d", low);
        tick();
        o_ready = 1'b0;
        wdata   = '0;

        // Backend timeout
        tick();
        addr_phase(32'h300, HSIZE_WORD, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
        push(32'h300, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        bus_idle();
        low = 0;
        repeat (6) begin
            @(negedge clk);
            if (!readyout && o_valid) low++;
            tick();
        end
        @(negedge clk);
        chk("to_wait_cycles", 64'(low), 64'd6);
        chk("to_err1_ready", 64'(readyout), 64'd0);
        chk("to_err1_resp", 64'(resp), 64'd1);
        chk("to_err1_valid", 64'(o_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("to_err2_ready", 64'(readyout), 64'd1);
        chk("to_err2_resp", 64'(resp), 64'd1);
        tick();
        @(negedge clk);
        chk("to_idle_resp", 64'(resp), 64'd0);
        $display("timeout read 0x300 wait=%0d", low);

        // Illegal transfers
        expect_error("misalign", 32'h102, HSIZE_WORD);
        expect_error("oversize", 32'h108, HSIZE_DWORD);

        // INCR4 burst, backend always ready
        o_ready = 1'b1;
        o_rdata = 32'hA5A50000;
        tick();
        addr_phase(32'h0, HSIZE_WORD, 1'b0, HTRANS_NONSEQ, HBURST_INCR4);
        push(32'h0, HSIZE_WORD, 1'b0, 32'h0);
        vcnt = 0;
        for (int b = 1; b < 4; b++) begin
            @(negedge clk);
            if (o_valid && readyout) vcnt++;
            tick();
            addr_phase(32'(4 * b), HSIZE_WORD, 1'b0, HTRANS_SEQ, HBURST_INCR4);
            push(32'(4 * b), HSIZE_WORD, 1'b0, 32'h0);
        end
        @(negedge clk);
        if (o_valid && readyout) vcnt++;
        tick();
        bus_idle();
        @(negedge clk);
        if (o_valid && readyout) vcnt++;
        chk("burst_rdata", 64'(rdata), 64'hA5A50000);
        tick();
        @(negedge clk);
        chk("burst_valid_beats", 64'(vcnt), 64'd4);
        chk("burst_end_valid", 64'(o_valid), 64'd0);
        $display("incr4 burst beats=%0d", vcnt);

        // Burst with a BUSY beat
        tick();
        addr_phase(32'h10, HSIZE_WORD, 1'b0, HTRANS_NONSEQ, HBURST_INCR);
        push(32'h10, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        addr_phase(32'h14, HSIZE_WORD, 1'b0, HTRANS_BUSY, HBURST_INCR);
        @(negedge clk);
        chk("busy_prev_valid", 64'(o_valid), 64'd1);
        tick();
        addr_phase(32'h14, HSIZE_WORD, 1'b0, HTRANS_SEQ, HBURST_INCR);
        push(32'h14, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge clk);
        chk("busy_valid", 64'(o_valid), 64'd0);
        chk("busy_ready", 64'(readyout), 64'd1);
        chk("busy_resp", 64'(resp), 64'd0);
        tick();
        bus_idle();
        @(negedge clk);
        chk("busy_next_valid", 64'(o_valid), 64'd1);
        $display("busy beat handled, next beat addr=%h", o_addr);
        tick();
        o_ready = 1'b0;
        @(negedge clk);

        // Reset while waiting on the backend
        tick();
        addr_phase(32'h400, HSIZE_WORD, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
        push(32'h400, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        bus_idle();
        @(negedge clk);
        chk("rstmid_valid_before", 64'(o_valid), 64'd1);
        chk("rstmid_ready_before", 64'(readyout), 64'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("rstmid_valid", 64'(o_valid), 64'd0);
        chk("rstmid_ready", 64'(readyout), 64'd1);
        chk("rstmid_resp", 64'(resp), 64'd0);
        chk("rstmid_rdata", 64'(rdata), 64'd0);
        $display("reset asserted mid-access");
        tick();
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("rstmid_after_valid", 64'(o_valid), 64'd0);
        chk("rstmid_after_ready", 64'(readyout), 64'd1);
        tick();
        addr_phase(32'h500, HSIZE_WORD, 1'b0, HTRANS_NONSEQ, HBURST_SINGLE);
        push(32'h500, HSIZE_WORD, 1'b0, 32'h0);
        @(negedge clk);
        tick();
        bus_idle();
        o_ready = 1'b1;
        o_rdata = 32'h12345678;
        @(negedge clk);
        chk("post_rst_rdata", 64'(rdata), 64'h12345678);
        chk("post_rst_done", 64'(readyout), 64'd1);
        $display("read 0x500 after reset rdata=%h", rdata);
        tick();
        o_ready = 1'b0;
        @(negedge clk);

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
